// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter that locks one requester onto a shared streaming port for a whole burst.
// Grant is decided in IDLE, and beats flow combinationally through the mux while LOCKED.
module shared_port_arbiter #(
  parameter int unsigned PORTCOUNT     = 4,
  parameter int unsigned PORTADDRWIDTH = 2,
  parameter int unsigned DATAWIDTH     = 16,
  parameter int unsigned BEATWIDTH     = 8
) (
  input  logic                           clk,
  input  logic                           sync_rst,
  input  logic                           clk_en,
  input  logic [PORTCOUNT-1:0]           ReqValid,
  input  logic [PORTCOUNT*DATAWIDTH-1:0] ReqData,
  input  logic [PORTCOUNT-1:0]           ReqLast,
  output logic [PORTCOUNT-1:0]           ReqReady,
  output logic                           OutValid,
  output logic [DATAWIDTH-1:0]           OutData,
  output logic                           OutLast,
  output logic [PORTADDRWIDTH-1:0]       OutPort,
  input  logic                           OutReady,
  output logic [BEATWIDTH-1:0]           BeatCount
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                   state_q, state_d;
  logic [PORTADDRWIDTH-1:0] ptr_q, ptr_d;
  logic [PORTADDRWIDTH-1:0] grant_q, grant_d;
  logic [BEATWIDTH-1:0]     beat_q, beat_d;
  logic [PORTADDRWIDTH-1:0] pick, idx;
  logic                     pick_found;
  logic                     xfer;

  // First requester at or after ptr_q; the index wraps naturally since PORTCOUNT is a power of two.
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    idx        = ptr_q;
    for (int unsigned i = 0; i < PORTCOUNT; i++) begin
      idx = ptr_q + PORTADDRWIDTH'(i);
      if (!pick_found && ReqValid[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  // Every output is forced quiet during reset so no beat can complete in the reset cycle.
  always_comb begin
    ReqReady  = '0;
    OutValid  = 1'b0;
    OutData   = '0;
    OutLast   = 1'b0;
    OutPort   = ptr_q;
    BeatCount = beat_q;
    xfer      = 1'b0;
    if (sync_rst) begin
      OutPort   = '0;
      BeatCount = '0;
    end else if (state_q == StLocked) begin
      OutValid          = ReqValid[grant_q] & clk_en;
      OutData           = ReqData[32'(grant_q) * DATAWIDTH +: DATAWIDTH];
      OutLast           = ReqLast[grant_q];
      OutPort           = grant_q;
      ReqReady[grant_q] = OutReady & clk_en;
      xfer              = OutValid & OutReady;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    if (clk_en) begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_d = pick;
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (xfer) begin
            if (beat_q != '1) beat_d = beat_q + BEATWIDTH'(1);
            if (OutLast) begin
              state_d = StIdle;
              ptr_d   = grant_q + PORTADDRWIDTH'(1);
              beat_d  = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Randomised and directed bench for shared_port_arbiter against a burst-level reference model.
module tb_shared_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int BW = 3;

  logic            clk = 1'b0;
  logic            sync_rst, clk_en, OutReady;
  logic [N-1:0]    ReqValid, ReqLast, ReqReady;
  logic [N*DW-1:0] ReqData;
  logic            OutValid, OutLast;
  logic [DW-1:0]   OutData;
  logic [AW-1:0]   OutPort;
  logic [BW-1:0]   BeatCount;

  shared_port_arbiter #(
    .PORTCOUNT    (N),
    .PORTADDRWIDTH(AW),
    .DATAWIDTH    (DW),
    .BEATWIDTH    (BW)
  ) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .clk_en   (clk_en),
    .ReqValid (ReqValid),
    .ReqData  (ReqData),
    .ReqLast  (ReqLast),
    .ReqReady (ReqReady),
    .OutValid (OutValid),
    .OutData  (OutData),
    .OutLast  (OutLast),
    .OutPort  (OutPort),
    .OutReady (OutReady),
    .BeatCount(BeatCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: burst owner, round-robin start point and beats moved in this burst.
  bit m_locked;
  int m_grant, m_ptr, m_beat;
  int xfer_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_req(input logic [N-1:0] rv, input int start);
    for (int i = 0; i < N; i++) if (rv[(start + i) % N]) return (start + i) % N;
    return -1;
  endfunction

  // One clock: outputs compared at the falling edge, model advanced, inputs changeable after #1.
  task automatic step();
    logic          e_valid, e_last;
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_ready;
    int            e_port, e_beat, pick;
    @(negedge clk);
    e_valid = 1'b0; e_last = 1'b0; e_data = '0; e_ready = '0;
    e_port  = m_ptr; e_beat = m_beat;
    if (sync_rst) begin
      e_port = 0; e_beat = 0;
    end else if (m_locked) begin
      e_valid = ReqValid[m_grant] & clk_en;
      e_data  = ReqData[m_grant*DW +: DW];
      e_last  = ReqLast[m_grant];
      e_port  = m_grant;
      e_ready[m_grant] = OutReady & clk_en;
    end
    check_eq("OutValid", 32'(OutValid), 32'(e_valid));
    check_eq("OutData", 32'(OutData), 32'(e_data));
    check_eq("OutLast", 32'(OutLast), 32'(e_last));
    check_eq("OutPort", 32'(OutPort), 32'(e_port));
    check_eq("ReqReady", 32'(ReqReady), 32'(e_ready));
    check_eq("BeatCount", 32'(BeatCount), 32'(e_beat));
    if (OutValid && OutReady) xfer_log.push_back(int'(OutPort));
    if (sync_rst) begin
      m_locked = 0; m_ptr = 0; m_grant = 0; m_beat = 0;
    end else if (clk_en) begin
      if (!m_locked) begin
        pick = first_req(ReqValid, m_ptr);
        if (pick >= 0) begin
          m_locked = 1; m_grant = pick;
        end
      end else if (ReqValid[m_grant] && OutReady) begin
        m_beat = (m_beat < (1 << BW) - 1) ? m_beat + 1 : m_beat;
        if (ReqLast[m_grant]) begin
          m_locked = 0; m_ptr = (m_grant + 1) % N; m_beat = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    ReqData = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    sync_rst = 1'b1;
    step();
    step();
    sync_rst = 1'b0;
  endtask

  initial begin
    sync_rst = 1'b1; clk_en = 1'b1; OutReady = 1'b0;
    ReqValid = '0; ReqLast = '0; ReqData = '0;
    m_locked = 0; m_grant = 0; m_ptr = 0; m_beat = 0;
    #1;
    do_reset();

    // Two alternating single-beat requesters.
    ReqValid = 4'b0101; ReqLast = 4'b1111; OutReady = 1'b1;
    xfer_log.delete();
    for (int i = 0; i < 8; i++) step();
    check_eq("alt_count", 32'(xfer_log.size()), 32'd4);
    for (int i = 0; i < xfer_log.size(); i++) check_eq("alt_order", 32'(xfer_log[i]), 32'((i % 2) * 2));

    // Pointer now 3: port 3 first, then wrap to port 0.
    ReqValid = 4'b1001;
    xfer_log.delete();
    for (int i = 0; i < 4; i++) step();
    check_eq("wrap_count", 32'(xfer_log.size()), 32'd2);
    if (xfer_log.size() == 2) begin
      check_eq("wrap_first", 32'(xfer_log[0]), 32'd3);
      check_eq("wrap_second", 32'(xfer_log[1]), 32'd0);
    end

    // Port 1 four-beat burst with throttled sink while port 2 waits.
    ReqValid = 4'b0110; xfer_log.delete();
    for (int i = 0; i < 40 && xfer_log.size() < 5; i++) begin
      ReqLast  = {2'b01, (m_locked && m_grant == 1 && m_beat == 3), 1'b0};
      OutReady = (i % 2 == 0);
      step();
    end
    check_eq("burst_count", 32'(xfer_log.size()), 32'd5);
    for (int i = 0; i < xfer_log.size(); i++) check_eq("burst_port", 32'(xfer_log[i]), (i < 4) ? 32'd1 : 32'd2);

    // Enable dropped for three cycles in the middle of a port 0 burst.
    ReqValid = 4'b0001; ReqLast = '0; OutReady = 1'b1; xfer_log.delete();
    for (int i = 0; i < 40 && xfer_log.size() < 4; i++) begin
      clk_en     = !(i >= 3 && i < 6);
      ReqLast[0] = (m_beat == 3);
      step();
    end
    clk_en = 1'b1;
    check_eq("stall_count", 32'(xfer_log.size()), 32'd4);

    // Reset during beat 2 of a port 3 burst, then ports 0 and 3 contend.
    ReqValid = 4'b1000; ReqLast = '0; xfer_log.delete();
    for (int i = 0; i < 10 && xfer_log.size() < 1; i++) step();
    check_eq("pre_rst_beat", 32'(xfer_log.size()), 32'd1);
    sync_rst = 1'b1;
    step();
    sync_rst = 1'b0;
    ReqValid = 4'b1001; ReqLast = 4'b1111; xfer_log.delete();
    for (int i = 0; i < 4; i++) step();
    check_eq("post_rst_len", 32'(xfer_log.size()), 32'd2);
    if (xfer_log.size() > 0) check_eq("post_rst_grant", 32'(xfer_log[0]), 32'd0);

    // Four continuous requesters: sixteen single-beat bursts in strict rotation.
    do_reset();
    ReqValid = 4'b1111; xfer_log.delete();
    for (int i = 0; i < 32; i++) step();
    check_eq("rr_count", 32'(xfer_log.size()), 32'd16);
    for (int i = 0; i < xfer_log.size(); i++) check_eq("rr_order", 32'(xfer_log[i]), 32'(i % 4));

    // Long bursts to reach saturation, then fully random traffic.
    ReqValid = 4'b0100; ReqLast = '0;
    for (int i = 0; i < 14; i++) step();
    for (int i = 0; i < 3000; i++) begin
      sync_rst = ($urandom_range(63) == 0);
      clk_en   = ($urandom_range(7) != 0);
      OutReady = ($urandom_range(3) != 0);
      ReqValid = N'($urandom);
      for (int p = 0; p < N; p++) ReqLast[p] = ($urandom_range(2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
